// File: rtl/proc_harness_pkg.sv
// Shared types for the load-and-run harness.
// State encoding and memory select constants.
package proc_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  localparam logic SEL_INSTR = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  function automatic logic is_busy(
    input state_e s
  );
    return (s == ST_LOAD) ||
           (s == ST_FLUSH) ||
           (s == ST_RUN);
  endfunction

  function automatic logic is_loading(
    input state_e s
  );
    return (s == ST_IDLE) ||
           (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter with clear/enable.
// Flags the cycle whose completion reaches MAX_CYCLES.
module run_watchdog #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count_inc,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MAX_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign count_inc = cnt_q + 1'b1;
  assign expired   = en &&
                     (count_inc == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proc_load_ctrl.sv
// Preloads instr/data memories from a beat stream,
// then runs the core and captures result or timeout.
module proc_load_ctrl
  import proc_harness_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sel,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              clear,
  output logic              core_rst,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr,
  output logic              ins_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data,
  output logic              data_we,
  input  logic              done,
  input  logic [DATA_W-1:0] processor_out,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  cycles,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MAX_CYCLES);

  state_e state_q, state_d;

  logic              core_rst_q, core_rst_d;
  logic [ADDR_W-1:0] ia_q, ia_d;
  logic [DATA_W-1:0] id_q, id_d;
  logic              iwe_q, iwe_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] dd_q, dd_d;
  logic              dwe_q, dwe_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              to_q, to_d;

  logic             accept;
  logic             in_run;
  logic [CNT_W-1:0] wd_inc;
  logic             wd_exp;

  assign in_run  = (state_q == ST_RUN);
  assign s_ready = is_loading(state_q) &
                   ~clear & ~rst;
  assign accept  = s_valid & s_ready;

  run_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clr       (~in_run),
    .en        (in_run),
    .count_inc (wd_inc),
    .expired   (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    ia_d    = ia_q;
    id_d    = id_q;
    iwe_d   = 1'b0;
    da_d    = da_q;
    dd_d    = dd_q;
    dwe_d   = 1'b0;
    rv_d    = rv_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    to_d    = to_q;

    if (accept) begin
      if (s_sel == SEL_DATA) begin
        da_d  = s_addr;
        dd_d  = s_data;
        dwe_d = 1'b1;
      end else begin
        ia_d  = s_addr;
        id_d  = s_data;
        iwe_d = 1'b1;
      end
    end

    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rv_d    = 1'b0;
            to_d    = 1'b0;
            res_d   = '0;
            cyc_d   = '0;
            state_d = s_last ? ST_FLUSH
                             : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept && s_last) begin
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          // done beats the limit when both land
          if (done) begin
            state_d = ST_DONE;
            res_d   = processor_out;
            cyc_d   = wd_inc;
            rv_d    = 1'b1;
          end else if (wd_exp) begin
            state_d = ST_TIMEOUT;
            cyc_d   = LIMIT;
            to_d    = 1'b1;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    core_rst_d = (state_d != ST_RUN);
    busy_d     = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      core_rst_q <= 1'b1;
      ia_q       <= '0;
      id_q       <= '0;
      iwe_q      <= 1'b0;
      da_q       <= '0;
      dd_q       <= '0;
      dwe_q      <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      res_q      <= '0;
      cyc_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      ia_q       <= ia_d;
      id_q       <= id_d;
      iwe_q      <= iwe_d;
      da_q       <= da_d;
      dd_q       <= dd_d;
      dwe_q      <= dwe_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      res_q      <= res_d;
      cyc_q      <= cyc_d;
      to_q       <= to_d;
    end
  end

  assign core_rst     = core_rst_q;
  assign instr_addr   = ia_q;
  assign instr        = id_q;
  assign ins_we       = iwe_q;
  assign data_addr    = da_q;
  assign data         = dd_q;
  assign data_we      = dwe_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result       = res_q;
  assign cycles       = cyc_q;
  assign timeout_err  = to_q;

endmodule

// File: tb/tb_proc_load_ctrl.sv
// Bench for proc_load_ctrl: stub core, write scoreboard,
// table-driven run cases and randomized programs.
module tb_proc_load_ctrl;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_sel = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          clear = 1'b0;
  logic          core_rst;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr;
  logic          ins_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data;
  logic          data_we;
  logic          done = 1'b0;
  logic [DW-1:0] processor_out = '0;
  logic          busy;
  logic          result_valid;
  logic [DW-1:0] result;
  logic [CW-1:0] cycles;
  logic          timeout_err;

  proc_load_ctrl #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .CNT_W      (CW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_sel         (s_sel),
    .s_addr        (s_addr),
    .s_data        (s_data),
    .s_last        (s_last),
    .clear         (clear),
    .core_rst      (core_rst),
    .instr_addr    (instr_addr),
    .instr         (instr),
    .ins_we        (ins_we),
    .data_addr     (data_addr),
    .data          (data),
    .data_we       (data_we),
    .done          (done),
    .processor_out (processor_out),
    .busy          (busy),
    .result_valid  (result_valid),
    .result        (result),
    .cycles        (cycles),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t iq[$];
  wr_t dq[$];
  wr_t mw;
  logic [AW-1:0] li_a = '0;
  logic [DW-1:0] li_d = '0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;
  bit mon_en = 0;

  // expected status after the latest run
  bit            e_rv  = 0;
  bit            e_to  = 0;
  logic [DW-1:0] e_res = '0;
  int            e_cyc = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // write scoreboard: each accepted beat must appear
  // once, in order, on its port; other ports hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (ins_we) begin
        if (iq.size() == 0) begin
          chk("spurious ins_we", ins_we, 0);
        end else begin
          mw   = iq.pop_front();
          li_a = mw.a;
          li_d = mw.d;
        end
      end
      if (data_we) begin
        if (dq.size() == 0) begin
          chk("spurious data_we", data_we, 0);
        end else begin
          mw   = dq.pop_front();
          ld_a = mw.a;
          ld_d = mw.d;
        end
      end
      chk("instr_addr", instr_addr, li_a);
      chk("instr", instr, li_d);
      chk("data_addr", data_addr, ld_a);
      chk("data", data, ld_d);
    end
  end

  task automatic beat(input bit sel,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input bit last);
    s_valid = 1'b1;
    s_sel   = sel;
    s_addr  = a;
    s_data  = d;
    s_last  = last;
    #1;
    chk("s_ready in load", s_ready, 1);
    if (s_ready) begin
      if (sel) dq.push_back('{a, d});
      else     iq.push_back('{a, d});
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      done = 1'($urandom);
      processor_out = $urandom;
      beat(1'($urandom), AW'($urandom),
           $urandom, i == n - 1);
      if (i == 0) begin
        chk("first beat clears rv", result_valid, 0);
        chk("first beat clears to", timeout_err, 0);
        chk("first beat clears cyc", cycles, 0);
        chk("first beat clears res", result, 0);
      end
      if (i != n - 1) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  // called at the FLUSH-cycle negedge
  task automatic run_stub(input int k,
                          input logic [DW-1:0] val,
                          output int low);
    int g = 0;
    low = 0;
    while (core_rst && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("core_rst fall latency", g, 1);
    while (!core_rst && low < 200) begin
      low++;
      done          = (low == k);
      processor_out = val;
      @(negedge clk);
    end
    done = 1'b0;
    chk("core reheld after run", core_rst, 1);
  endtask

  task automatic check_result(input int k,
                              input logic [DW-1:0] val,
                              input int low);
    e_to  = (k > MAXC);
    e_rv  = !e_to;
    e_cyc = e_to ? MAXC : k;
    e_res = e_to ? '0 : val;
    chk("run length", low, e_cyc);
    chk("result_valid", result_valid, e_rv);
    chk("timeout_err", timeout_err, e_to);
    chk("cycles", cycles, e_cyc);
    chk("result", result, e_res);
    chk("busy after run", busy, 0);
    chk("instr writes drained", iq.size(), 0);
    chk("data writes drained", dq.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("s_ready low on clear", s_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("idle after clear", s_ready, 1);
    chk("busy after clear", busy, 0);
    chk("rv held by clear", result_valid, e_rv);
    chk("to held by clear", timeout_err, e_to);
    chk("cyc held by clear", cycles, e_cyc);
    chk("res held by clear", result, e_res);
  endtask

  task automatic reset_checks();
    chk("rst core_rst", core_rst, 1);
    chk("rst s_ready", s_ready, 0);
    chk("rst ins_we", ins_we, 0);
    chk("rst data_we", data_we, 0);
    chk("rst instr_addr", instr_addr, 0);
    chk("rst instr", instr, 0);
    chk("rst data_addr", data_addr, 0);
    chk("rst data", data, 0);
    chk("rst busy", busy, 0);
    chk("rst result_valid", result_valid, 0);
    chk("rst result", result, 0);
    chk("rst cycles", cycles, 0);
    chk("rst timeout_err", timeout_err, 0);
  endtask

  typedef struct {
    int            k;
    logic [DW-1:0] val;
    int            nbeats;
  } vec_t;

  vec_t tbl[6];
  int   low;

  initial begin
    tbl[0] = '{7,    32'hDEADBEEF, 3};
    tbl[1] = '{20,   32'h0000_0014, 2};
    tbl[2] = '{1000, 32'h1111_2222, 4};
    tbl[3] = '{1,    32'hA5A5_5A5A, 1};
    tbl[4] = '{21,   32'h0BAD_F00D, 2};
    tbl[5] = '{19,   32'hFFFF_FFFF, 5};

    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    #1;
    chk("s_ready after rst", s_ready, 1);
    mon_en = 1;

    // single last beat straight from IDLE
    beat(0, 10'd3, 32'hFC00_0000, 1);
    chk("single ins_we", ins_we, 1);
    chk("single data_we", data_we, 0);
    chk("single addr", instr_addr, 3);
    chk("flush core_rst", core_rst, 1);
    chk("flush busy", busy, 1);
    @(negedge clk);
    chk("run core_rst", core_rst, 0);
    chk("run ins_we", ins_we, 0);
    s_valid = 1'b1;
    s_addr  = 10'd7;
    processor_out = 32'h0000_000F;
    #1;
    chk("s_ready in run", s_ready, 0);
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done    = 1'b0;
    s_valid = 1'b0;
    chk("single done core_rst", core_rst, 1);
    chk("single cycles", cycles, 3);
    chk("single rv", result_valid, 1);
    chk("single result", result, 32'hF);
    e_rv = 1; e_to = 0; e_cyc = 3; e_res = 32'hF;

    foreach (tbl[i]) begin
      do_clear();
      load_prog(tbl[i].nbeats);
      run_stub(tbl[i].k, tbl[i].val, low);
      check_result(tbl[i].k, tbl[i].val, low);
    end

    // clear while a beat is offered in LOAD
    do_clear();
    beat(1, 10'd5, 32'h1234, 0);
    s_valid = 1'b1;
    s_sel   = 1'b0;
    s_addr  = 10'd9;
    clear   = 1'b1;
    #1;
    chk("clear blocks beat", s_ready, 0);
    @(negedge clk);
    clear   = 1'b0;
    s_valid = 1'b0;
    chk("clear ins_we", ins_we, 0);
    chk("clear data_we", data_we, 0);
    chk("clear busy", busy, 0);
    e_rv = 0; e_to = 0; e_cyc = 0; e_res = '0;

    for (int r = 0; r < 25; r++) begin
      int            k;
      logic [DW-1:0] v;
      k = $urandom_range(1, 24);
      v = $urandom;
      do_clear();
      load_prog($urandom_range(1, 8));
      run_stub(k, v, low);
      check_result(k, v, low);
    end

    // reset in the middle of RUN
    do_clear();
    load_prog(3);
    @(negedge clk);
    chk("pre-rst run", core_rst, 0);
    @(negedge clk);
    mon_en = 0;
    rst = 1'b1;
    @(negedge clk);
    reset_checks();
    iq.delete();
    dq.delete();
    li_a = '0; li_d = '0;
    ld_a = '0; ld_d = '0;
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
